// File: rtl/riscv_trace_monitor_if.sv
// Read-side handshake bundle of the trace monitor: oldest {pc, ins} entry over valid/ready.
interface riscv_trace_monitor_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            rd_valid;
    logic            rd_ready;
    logic [XLEN-1:0] rd_pc;
    logic [ILEN-1:0] rd_ins;

    modport master (output rd_valid, rd_pc, rd_ins, input rd_ready);
    modport slave  (input rd_valid, rd_pc, rd_ins, output rd_ready);
endinterface

// File: rtl/riscv_trace_monitor.sv
// Execution-trace monitor: circular {pc, ins} capture buffer, halt/timeout detection, drain port.
// Optional TRACE_DEDUP_EN: only push when the PC differs from the last pushed PC.
//
// state   | meaning
// IDLE    | not capturing; buffer and flags retained
// RUN     | capturing one sample per cycle, counting cycles
// HALTED  | PC stuck for HALT_CYCLES repeats; leave via clear/reset
// TIMEOUT | RUN cycle budget exhausted; leave via clear/reset
module riscv_trace_monitor #(
    parameter int XLEN        = 32,
    parameter int ILEN        = 32,
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [XLEN-1:0]          PC,
    input  logic [ILEN-1:0]          ins,
    input  logic                     capture_en,
    input  logic                     clear,
    riscv_trace_monitor_if.master    rd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     halted,
    output logic                     timeout,
    output logic [31:0]              cycle_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(HALT_CYCLES + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT_ST} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [SW-1:0]     stall_cnt;
    logic [XLEN-1:0]   prev_pc;
    logic [XLEN+ILEN-1:0] mem [DEPTH];
    logic [XLEN+ILEN-1:0] rd_word;

    logic run_cycle, pc_rep, halt_hit, to_hit, keep, push, pop, full;

`ifdef TRACE_DEDUP_EN
    logic [XLEN-1:0] last_pc;
    logic            pushed_any;

    assign keep = !pushed_any || (PC != last_pc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_pc    <= '0;
            pushed_any <= 1'b0;
        end else if (clear) begin
            last_pc    <= '0;
            pushed_any <= 1'b0;
        end else if (push) begin
            last_pc    <= PC;
            pushed_any <= 1'b1;
        end
    end
`else
    assign keep = 1'b1;
`endif

    // The cycle that leaves IDLE already counts as a RUN sample.
    assign run_cycle = capture_en && !clear && (state == IDLE || state == RUN);
    assign pc_rep    = (PC == prev_pc);
    assign halt_hit  = run_cycle && pc_rep && (stall_cnt == SW'(HALT_CYCLES - 1));
    assign to_hit    = run_cycle && (cycle_cnt == 32'(TIMEOUT - 1));
    assign push      = run_cycle && keep;
    assign pop       = rd.rd_valid && rd.rd_ready && !clear;
    assign full      = (count == CW'(DEPTH));

    assign rd_word     = mem[rd_ptr];
    assign rd.rd_valid = (count != '0);
    assign rd.rd_pc    = rd.rd_valid ? rd_word[XLEN+ILEN-1:ILEN] : '0;
    assign rd.rd_ins   = rd.rd_valid ? rd_word[ILEN-1:0] : '0;

    assign halted  = (state == HALTED);
    assign timeout = (state == TIMEOUT_ST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, RUN: begin
                if (!capture_en)   state_nxt = IDLE;
                else if (halt_hit) state_nxt = HALTED;
                else if (to_hit)   state_nxt = TIMEOUT_ST;
                else               state_nxt = RUN;
            end
            default: state_nxt = state;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {PC, ins};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            cycle_cnt <= '0;
            stall_cnt <= '0;
            prev_pc   <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            cycle_cnt <= '0;
            stall_cnt <= '0;
            prev_pc   <= '0;
        end else begin
            if (run_cycle) begin
                prev_pc   <= PC;
                stall_cnt <= pc_rep ? stall_cnt + SW'(1) : '0;
                if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            // When full, the write lands on the oldest slot, so the read side must skip it.
            if (pop || (push && full)) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop && !full)  count <= count + CW'(1);
            else if (pop && !push)      count <= count - CW'(1);
            if (push && full && !pop)   overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_trace_monitor.sv
// Directed self-checking bench for riscv_trace_monitor (default parameters).
module tb_riscv_trace_monitor;
    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] ins;
    logic        capture_en;
    logic        clear;
    logic [4:0]  count;
    logic        overflow;
    logic        halted;
    logic        timeout;
    logic [31:0] cycle_cnt;

    int total = 0;
    int bad   = 0;

`ifdef TRACE_DEDUP_EN
    localparam int DEDUP_CNT = 3;
`else
    localparam int DEDUP_CNT = 5;
`endif

    riscv_trace_monitor_if #(.XLEN(32), .ILEN(32)) rd_if ();

    riscv_trace_monitor #(
        .XLEN(32), .ILEN(32), .DEPTH(16), .HALT_CYCLES(4), .TIMEOUT(1024)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .ins        (ins),
        .capture_en (capture_en),
        .clear      (clear),
        .rd         (rd_if),
        .count      (count),
        .overflow   (overflow),
        .halted     (halted),
        .timeout    (timeout),
        .cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ins_of(input logic [31:0] p);
        return p ^ 32'hA5A5_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic drive(input logic [31:0] p);
        PC  = p;
        ins = ins_of(p);
    endtask

    initial begin
        reset = 1'b0; capture_en = 1'b0; clear = 1'b0;
        PC = '0; ins = '0; rd_if.rd_ready = 1'b0;

        // reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_count_low", 64'(count), 64'd0);
        reset = 1'b1;
        #1;
        check("rst_valid", 64'(rd_if.rd_valid), 64'd0);
        check("rst_pc", 64'(rd_if.rd_pc), 64'd0);
        check("rst_ins", 64'(rd_if.rd_ins), 64'd0);
        check("rst_flags", 64'({overflow, halted, timeout}), 64'd0);
        check("rst_cycle", 64'(cycle_cnt), 64'd0);

        // three captures then drain in order
        capture_en = 1'b1;
        drive(32'h0); tick();
        drive(32'h4); tick();
        drive(32'h8); tick();
        capture_en = 1'b0;
        check("cap3_count", 64'(count), 64'd3);
        check("cap3_valid", 64'(rd_if.rd_valid), 64'd1);
        check("cap3_ins0", 64'(rd_if.rd_ins), 64'(ins_of(32'h0)));
        check("cap3_cycle", 64'(cycle_cnt), 64'd3);
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("pop_pc", 64'(rd_if.rd_pc), 64'(4 * i));
            tick();
        end
        rd_if.rd_ready = 1'b0;
        check("drained_count", 64'(count), 64'd0);
        check("drained_valid", 64'(rd_if.rd_valid), 64'd0);
        check("drained_pc", 64'(rd_if.rd_pc), 64'd0);

        // overflow: 20 distinct PCs into 16 entries
        do_clear();
        check("clr_cycle", 64'(cycle_cnt), 64'd0);
        capture_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(32'h100 + 32'(4 * i));
            tick();
        end
        capture_en = 1'b0;
        check("ovf_count", 64'(count), 64'd16);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_oldest_pc", 64'(rd_if.rd_pc), 64'h110);
        check("ovf_oldest_ins", 64'(rd_if.rd_ins), 64'(ins_of(32'h110)));
        rd_if.rd_ready = 1'b1;
        tick();
        rd_if.rd_ready = 1'b0;
        check("ovf_pop_pc", 64'(rd_if.rd_pc), 64'h114);
        check("ovf_pop_count", 64'(count), 64'd15);
        check("ovf_sticky", 64'(overflow), 64'd1);
        do_clear();
        check("clr_overflow", 64'(overflow), 64'd0);
        check("clr_count", 64'(count), 64'd0);

        // empty + push + ready: no bypass
        capture_en = 1'b1; rd_if.rd_ready = 1'b1;
        drive(32'h40);
        tick();
        capture_en = 1'b0;
        check("nobyp_count", 64'(count), 64'd1);
        check("nobyp_pc", 64'(rd_if.rd_pc), 64'h40);
        tick();
        rd_if.rd_ready = 1'b0;
        check("nobyp_popped", 64'(count), 64'd0);

        // halt on stuck PC
        do_clear();
        capture_en = 1'b1;
        drive(32'h10);
        repeat (4) tick();
        check("halt_not_yet", 64'(halted), 64'd0);
        check("halt_pre_count", 64'(count), 64'd4);
        tick();
        check("halt_set", 64'(halted), 64'd1);
        check("halt_count", 64'(count), 64'd5);
        check("halt_no_to", 64'(timeout), 64'd0);
        repeat (2) tick();
        check("halt_frozen", 64'(count), 64'd5);
        check("halt_cycle", 64'(cycle_cnt), 64'd5);
        check("halt_hold", 64'(halted), 64'd1);
        capture_en = 1'b0;
        do_clear();
        check("halt_clr", 64'(halted), 64'd0);
        check("halt_clr_count", 64'(count), 64'd0);
        tick();
        check("idle_no_cap", 64'(count), 64'd0);

        // timeout after 1024 RUN cycles
        capture_en = 1'b1;
        for (int i = 0; i < 1023; i++) begin
            drive(32'h1000 + 32'(4 * i));
            tick();
        end
        check("to_not_yet", 64'(timeout), 64'd0);
        check("to_cycle_1023", 64'(cycle_cnt), 64'd1023);
        drive(32'h1000 + 32'(4 * 1023));
        tick();
        check("to_set", 64'(timeout), 64'd1);
        check("to_cycle", 64'(cycle_cnt), 64'd1024);
        check("to_not_halted", 64'(halted), 64'd0);
        check("to_count", 64'(count), 64'd16);
        for (int i = 0; i < 3; i++) begin
            drive(32'h9000 + 32'(4 * i));
            tick();
        end
        check("to_cycle_hold", 64'(cycle_cnt), 64'd1024);
        check("to_oldest_pc", 64'(rd_if.rd_pc), 64'(32'h1000 + 32'(4 * 1008)));
        capture_en = 1'b0;
        do_clear();
        check("to_clr", 64'(timeout), 64'd0);

        // dedup sequence, then async reset mid-run
        capture_en = 1'b1;
        drive(32'h0); tick();
        drive(32'h0); tick();
        drive(32'h4); tick();
        drive(32'h4); tick();
        drive(32'h8); tick();
        check("dedup_count", 64'(count), 64'(DEDUP_CNT));
        check("dedup_first_pc", 64'(rd_if.rd_pc), 64'd0);
        drive(32'hC);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_valid", 64'(rd_if.rd_valid), 64'd0);
        check("midrst_cycle", 64'(cycle_cnt), 64'd0);
        capture_en = 1'b0;
        tick();
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
